// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the alu_ip round-robin arbiter/sequencer.
package alu_arb_pkg;

   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;
   localparam int N_REQ  = 4;
   localparam int ID_W   = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_t;

   // Tag id is sized from this package; resize N_REQ here together with the top.
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, wrapping mod N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   int               cand;
   logic [IDX_W-1:0] cidx;
   logic             found;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      cidx    = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         cidx = IDX_W'(cand);
         if (en && !found && req[cidx]) begin
            found     = 1'b1;
            gnt[cidx] = 1'b1;
            gnt_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered alu_ip between N_REQ requesters; tags each issue with its requester
// id and returns C/Z with that id once the ALU latency has elapsed.
module alu_arbiter #(
   parameter int N_REQ   = alu_arb_pkg::N_REQ,
   parameter int DATA_W  = alu_arb_pkg::DATA_W,
   parameter int SEL_W   = alu_arb_pkg::SEL_W,
   parameter int ALU_LAT = 1,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic                    busy,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_a,
   input  logic [N_REQ*DATA_W-1:0] req_b,
   input  logic [N_REQ*SEL_W-1:0]  req_sel,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_c,
   output logic                    rsp_z,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   output logic [SEL_W-1:0]        alu_sel,
   input  logic [DATA_W-1:0]       alu_c,
   input  logic                    alu_z
);

   import alu_arb_pkg::*;

   arb_state_t      state, state_nxt;
   logic [ID_W-1:0] ptr;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0] gnt_idx;
   logic            issue_en;
   logic            xfer;
   logic            pend;
   tag_t            tag_q [ALU_LAT+1];

   rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_rr (
      .req     (req_valid),
      .ptr     (ptr),
      .en      (issue_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // pend: operations whose response has not yet reached the output stage.
   always_comb begin
      pend = 1'b0;
      for (int j = 0; j < ALU_LAT; j++) pend = pend | tag_q[j].vld;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = pend ? DRAIN : IDLE;
         DRAIN:   if (!pend) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue_en  = !rst && (state == RUN) && en;
      req_ready = gnt;
      xfer      = |gnt;
      busy      = (state != IDLE) || pend || tag_q[ALU_LAT].vld;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         // NOTE: the tag array is reset because its valid bits decide what is in flight.
         for (int j = 0; j <= ALU_LAT; j++) tag_q[j] <= '0;
      end else begin
         if (xfer) begin
            ptr     <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
            alu_a   <= req_a[gnt_idx*DATA_W +: DATA_W];
            alu_b   <= req_b[gnt_idx*DATA_W +: DATA_W];
            alu_sel <= req_sel[gnt_idx*SEL_W +: SEL_W];
         end
         tag_q[0] <= '{vld: xfer, id: gnt_idx};
         for (int j = 1; j <= ALU_LAT; j++) tag_q[j] <= tag_q[j-1];
      end
   end

   assign rsp_valid = tag_q[ALU_LAT].vld;
   assign rsp_id    = tag_q[ALU_LAT].id;
   assign rsp_c     = alu_c;
   assign rsp_z     = alu_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural alu_ip and a queue-based
// reference model of grant order, issue registers and tagged responses.
module tb_alu_arbiter;

   localparam int N_REQ   = 4;
   localparam int DATA_W  = 8;
   localparam int SEL_W   = 3;
   localparam int ALU_LAT = 1;
   localparam int ID_W    = 2;

   logic                    clk = 1'b0;
   logic                    rst, en, busy;
   logic [N_REQ-1:0]        req_valid, req_ready;
   logic [N_REQ*DATA_W-1:0] req_a, req_b;
   logic [N_REQ*SEL_W-1:0]  req_sel;
   logic                    rsp_valid, rsp_z, alu_z;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_c, alu_a, alu_b, alu_c;
   logic [SEL_W-1:0]        alu_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .ALU_LAT(ALU_LAT), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .en(en), .busy(busy),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_z(rsp_z),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_c(alu_c), .alu_z(alu_z)
   );

   function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [SEL_W-1:0] s);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return $signed(a) >>> 1;
      endcase
   endfunction

   // Registered alu_ip stand-in.
   logic [DATA_W-1:0] alu_pipe [ALU_LAT];
   always @(posedge clk) begin
      alu_pipe[0] <= alu_f(alu_a, alu_b, alu_sel);
      for (int j = 1; j < ALU_LAT; j++) alu_pipe[j] <= alu_pipe[j-1];
   end
   assign alu_c = alu_pipe[ALU_LAT-1];
   assign alu_z = (alu_c == '0);

   typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
   typedef struct {
      int                id;
      logic [DATA_W-1:0] c;
      logic              z;
      int                due;
   } exp_t;

   exp_t              q[$];
   mode_t             mode;
   int                mptr, cyc;
   logic [DATA_W-1:0] last_a, last_b;
   logic [SEL_W-1:0]  last_sel;
   logic [N_REQ-1:0]  vv;
   logic [DATA_W-1:0] va [N_REQ];
   logic [DATA_W-1:0] vb [N_REQ];
   logic [SEL_W-1:0]  vs [N_REQ];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic new_data(input int i);
      va[i] = DATA_W'($urandom);
      vb[i] = DATA_W'($urandom);
      vs[i] = SEL_W'($urandom_range(0, 7));
   endtask

   function automatic int first_valid();
      for (int k = 0; k < N_REQ; k++)
         if (vv[(mptr + k) % N_REQ]) return (mptr + k) % N_REQ;
      return -1;
   endfunction

   // One clock: drive inputs, check grant, advance the model, check registered outputs.
   task automatic tick(output int acc);
      logic [N_REQ-1:0] exp_rdy;
      logic             pend, exp_vld;
      exp_t             e;
      for (int i = 0; i < N_REQ; i++) begin
         req_a[i*DATA_W +: DATA_W] = va[i];
         req_b[i*DATA_W +: DATA_W] = vb[i];
         req_sel[i*SEL_W +: SEL_W] = vs[i];
      end
      req_valid = vv;
      #1;
      acc     = (mode == M_RUN && en && !rst) ? first_valid() : -1;
      exp_rdy = (acc >= 0) ? (N_REQ'(1) << acc) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      cyc++;
      pend = (q.size() > 0);
      if (rst) begin
         mode = M_IDLE; mptr = 0; q.delete();
         last_a = '0; last_b = '0; last_sel = '0;
      end else begin
         if (acc >= 0) begin
            e.id = acc; e.c = alu_f(va[acc], vb[acc], vs[acc]);
            e.z = (e.c == '0); e.due = cyc + ALU_LAT;
            q.push_back(e);
            last_a = va[acc]; last_b = vb[acc]; last_sel = vs[acc];
            mptr = (acc + 1) % N_REQ;
         end
         case (mode)
            M_IDLE:  if (en) mode = M_RUN;
            M_RUN:   if (!en) mode = pend ? M_DRAIN : M_IDLE;
            default: if (!pend) mode = M_IDLE;
         endcase
      end
      #1;
      check("alu_a", 32'(alu_a), 32'(last_a));
      check("alu_b", 32'(alu_b), 32'(last_b));
      check("alu_sel", 32'(alu_sel), 32'(last_sel));
      exp_vld = (q.size() > 0) && (q[0].due == cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
         check("rsp_id", 32'(rsp_id), 32'(q[0].id));
         check("rsp_c", 32'(rsp_c), 32'(q[0].c));
         check("rsp_z", 32'(rsp_z), 32'(q[0].z));
      end
      check("busy", 32'(busy), 32'(mode != M_IDLE || q.size() > 0));
      if (exp_vld) void'(q.pop_front());
   endtask

   initial begin
      int acc;
      rst = 1'b1; en = 1'b0; vv = '0;
      mode = M_IDLE; mptr = 0; cyc = 0;
      last_a = '0; last_b = '0; last_sel = '0;
      for (int i = 0; i < N_REQ; i++) new_data(i);

      // Reset state.
      tick(acc); tick(acc);
      rst = 1'b0;
      tick(acc);
      check("rsp_id_reset", 32'(rsp_id), 32'd0);

      // Single op from requester 2.
      en = 1'b1;
      tick(acc);
      vv[2] = 1'b1; va[2] = 8'd5; vb[2] = 8'd3; vs[2] = 3'd0;
      tick(acc);
      vv = '0;
      tick(acc); tick(acc);

      // All valid from pointer 0: strict rotation.
      rst = 1'b1; tick(acc); rst = 1'b0; tick(acc);
      vv = '1;
      for (int n = 0; n < 8; n++) begin
         tick(acc);
         if (acc >= 0) new_data(acc);
      end

      // Requesters 1 and 3 with the pointer moved to 2.
      vv = 4'b0010; tick(acc);
      vv = 4'b1010;
      for (int n = 0; n < 4; n++) tick(acc);

      // Three back-to-back ops, then en drops with requests still pending.
      vv = '1;
      for (int n = 0; n < 3; n++) tick(acc);
      en = 1'b0;
      for (int n = 0; n < 5; n++) tick(acc);
      vv = '0;

      // Reset with two ops in flight, then issue restarts at requester 0.
      en = 1'b1; tick(acc);
      vv = '1; tick(acc); tick(acc);
      rst = 1'b1; tick(acc);
      rst = 1'b0; tick(acc); tick(acc); tick(acc);

      // Every select with extreme operands from requester 1 alone.
      vv = 4'b0010; va[1] = 8'h80; vb[1] = 8'h7F;
      for (int s = 0; s < 8; s++) begin
         vs[1] = SEL_W'(s);
         tick(acc);
      end
      vv = '0;
      for (int n = 0; n < 3; n++) tick(acc);

      // Randomized traffic; valid and data are held until accepted.
      for (int n = 0; n < 400; n++) begin
         tick(acc);
         if (acc >= 0) begin
            new_data(acc);
            vv[acc] = 1'($urandom_range(0, 1));
         end
         for (int i = 0; i < N_REQ; i++)
            if (!vv[i] && $urandom_range(0, 2) == 0) begin
               new_data(i);
               vv[i] = 1'b1;
            end
         if ($urandom_range(0, 15) == 0) en = ~en;
         rst = ($urandom_range(0, 99) == 0);
      end
      rst = 1'b0; en = 1'b0; vv = '0;
      for (int n = 0; n < 6; n++) tick(acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
